// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue controller sharing one FP multiplier between two requesters.
// Tracks in-flight ops with a latency-matched tag pipe and supports drain.
module fmul_issue_arbiter #(
    parameter  int LAT = 3,
    parameter  int W   = 32,
    localparam int CW  = $clog2(LAT+2)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  opx0,
    input  logic [W-1:0]  opy0,
    input  logic [W-1:0]  opx1,
    input  logic [W-1:0]  opy1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          mul_vld,
    output logic [W-1:0]  mul_x,
    output logic [W-1:0]  mul_y,
    input  logic [W-1:0]  mul_res,
    output logic [W-1:0]  res_data,
    output logic          done0,
    output logic          done1,
    input  logic          drain_req,
    output logic          drained,
    output logic [CW-1:0] inflight
);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t       state;
    logic         ptr;
    logic         en;
    logic         gnt;
    logic         gid;
    logic [LAT:0] tv;
    logic [LAT:0] tid;

    // Grants are masked during reset so all outputs read as reset values
    assign en   = RST & (state == RUN) & ~drain_req;
    assign gnt0 = en & req0 & (~req1 | ~ptr);
    assign gnt1 = en & req1 & (~req0 | ptr);
    assign gnt  = gnt0 | gnt1;
    assign gid  = gnt1;

    assign drained = (state == DRAINED);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= RUN;
            ptr      <= 1'b0;
            mul_vld  <= 1'b0;
            mul_x    <= '0;
            mul_y    <= '0;
            tv       <= '0;
            tid      <= '0;
            res_data <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            inflight <= '0;
        end else begin
            mul_vld <= gnt;
            if (gnt) begin
                ptr   <= ~gid;
                mul_x <= gid ? opx1 : opx0;
                mul_y <= gid ? opy1 : opy0;
            end

            // Stage LAT lines up with mul_res; done registers one cycle later
            tv    <= {tv[LAT-1:0], gnt};
            tid   <= {tid[LAT-1:0], gid};
            done0 <= tv[LAT] & ~tid[LAT];
            done1 <= tv[LAT] & tid[LAT];
            if (tv[LAT]) begin
                res_data <= mul_res;
            end

            unique case ({gnt, tv[LAT]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            unique case (state)
                RUN: begin
                    if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state <= DRAINED;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Directed bench for fmul_issue_arbiter with a fixed-latency multiplier model.
// Each task drives one scenario and checks its own expectations inline.
module tb_fmul_issue_arbiter;

    parameter int LAT = 3;
    localparam int CW = $clog2(LAT+2);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [31:0]   opx0 = '0;
    logic [31:0]   opy0 = '0;
    logic [31:0]   opx1 = '0;
    logic [31:0]   opy1 = '0;
    logic          gnt0;
    logic          gnt1;
    logic          mul_vld;
    logic [31:0]   mul_x;
    logic [31:0]   mul_y;
    logic [31:0]   mul_res;
    logic [31:0]   res_data;
    logic          done0;
    logic          done1;
    logic          drain_req = 1'b0;
    logic          drained;
    logic [CW-1:0] inflight;

    fmul_issue_arbiter #(.LAT(LAT), .W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1),
        .opx0(opx0), .opy0(opy0), .opx1(opx1), .opy1(opy1),
        .gnt0(gnt0), .gnt1(gnt1),
        .mul_vld(mul_vld), .mul_x(mul_x), .mul_y(mul_y),
        .mul_res(mul_res), .res_data(res_data),
        .done0(done0), .done1(done1),
        .drain_req(drain_req), .drained(drained),
        .inflight(inflight)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Stand-in multiplier: sign xor, exponent add, mantissa xor
    function automatic logic [31:0] fmodel(input logic [31:0] x, input logic [31:0] y);
        logic [7:0] e;
        e = x[30:23] + y[30:23] - 8'd127;
        return {x[31] ^ y[31], e, x[22:0] ^ y[22:0]};
    endfunction

    logic [31:0] mp [LAT];
    always @(posedge CLK) begin
        mp[0] <= mul_vld ? fmodel(mul_x, mul_y) : 32'h0;
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mul_res = mp[LAT-1];

    typedef struct {
        int          c;
        int          id;
        logic [31:0] d;
    } ev_t;

    ev_t dq[$];
    int  max_inf = 0;

    always @(negedge CLK) begin
        if (done0 | done1) dq.push_back(ev_t'{cyc, done1 ? 1 : 0, res_data});
        if (int'(inflight) > max_inf) max_inf = int'(inflight);
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        drain_req = 1'b0;
        next();
        next();
        RST = 1'b1;
        dq.delete();
        max_inf = 0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        req0 = 1'b1;
        look();
        n_chk++;
        if ({gnt0, gnt1, mul_vld, done0, done1, drained} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_bits got %b want 000000",
                     {gnt0, gnt1, mul_vld, done0, done1, drained});
        end
        n_chk++;
        if (mul_x !== 32'h0 || mul_y !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mul_xy got %h/%h want 0/0", mul_x, mul_y);
        end
        n_chk++;
        if (res_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_res got %h want 0", res_data);
        end
        n_chk++;
        if (inflight !== CW'(0)) begin
            n_err++;
            $display("FAIL reset_inflight got %0d want 0", inflight);
        end
        req0 = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] exp_d;
        do_reset();
        opx0 = 32'h3F800000;
        opy0 = 32'h40000000;
        exp_d = 32'h40000000;
        req0 = 1'b1;
        look();
        n_chk++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_gnt got %b want 10", {gnt0, gnt1});
        end
        for (int k = 1; k <= LAT + 2; k++) begin
            next();
            if (k == 1) req0 = 1'b0;
            look();
            if (k == 1) begin
                n_chk++;
                if ({mul_vld, mul_x, mul_y} !== {1'b1, 32'h3F800000, 32'h40000000}) begin
                    n_err++;
                    $display("FAIL single_mul got %b %h %h want 1 3f800000 40000000",
                             mul_vld, mul_x, mul_y);
                end
                n_chk++;
                if (inflight !== CW'(1)) begin
                    n_err++;
                    $display("FAIL single_inflight1 got %0d want 1", inflight);
                end
            end
            n_chk++;
            if (done0 !== (k == LAT + 2)) begin
                n_err++;
                $display("FAIL single_done0 k=%0d got %b want %b", k, done0, k == LAT + 2);
            end
        end
        n_chk++;
        if (res_data !== exp_d || inflight !== CW'(0)) begin
            n_err++;
            $display("FAIL single_res got %h/%0d want %h/0", res_data, inflight, exp_d);
        end
        next();
        look();
        n_chk++;
        if (done0 !== 1'b0 || res_data !== exp_d) begin
            n_err++;
            $display("FAIL single_hold got %b/%h want 0/%h", done0, res_data, exp_d);
        end
    endtask

    task automatic test_contention();
        int          g0;
        int          exp_max;
        logic [31:0] ed [2];
        do_reset();
        opx0 = 32'h3F800000;
        opy0 = 32'h40400000;
        opx1 = 32'hC0000000;
        opy1 = 32'h40800000;
        ed[0] = fmodel(opx0, opy0);
        ed[1] = fmodel(opx1, opy1);
        req0 = 1'b1;
        req1 = 1'b1;
        g0 = 0;
        for (int i = 0; i < 6; i++) begin
            look();
            if (i == 0) g0 = cyc;
            n_chk++;
            if ({gnt0, gnt1} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL cont_gnt i=%0d got %b want %b", i, {gnt0, gnt1},
                         (i % 2 == 1) ? 2'b01 : 2'b10);
            end
            next();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (LAT + 6) next();
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (i >= dq.size()) begin
                n_err++;
                $display("FAIL cont_done i=%0d got none want one", i);
            end else if (dq[i].c !== g0 + i + LAT + 2 || dq[i].id !== i % 2 ||
                         dq[i].d !== ed[i % 2]) begin
                n_err++;
                $display("FAIL cont_done i=%0d got c%0d id%0d %h want c%0d id%0d %h",
                         i, dq[i].c, dq[i].id, dq[i].d, g0 + i + LAT + 2, i % 2, ed[i % 2]);
            end
        end
        exp_max = (LAT + 1 < 6) ? LAT + 1 : 6;
        n_chk++;
        if (max_inf !== exp_max || dq.size() !== 6) begin
            n_err++;
            $display("FAIL cont_inflight got max%0d n%0d want max%0d n6",
                     max_inf, dq.size(), exp_max);
        end
    endtask

    task automatic test_fairness();
        int w;
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0 = 1'b1;
            w = 0;
            look();
            while (gnt0 !== 1'b1 && w < 4) begin
                next();
                look();
                w++;
            end
            n_chk++;
            if (w > 1) begin
                n_err++;
                $display("FAIL fair_wait i=%0d got %0d want <=1", i, w);
            end
            next();
            if (i % 2 == 1) begin
                req0 = 1'b0;
                next();
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_drain();
        int d;
        int z;
        int r;
        int bad;
        int t;
        do_reset();
        opx0 = 32'h3F800000;
        opy0 = 32'h40000000;
        req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look();
            n_chk++;
            if (gnt0 !== 1'b1) begin
                n_err++;
                $display("FAIL drain_issue i=%0d got %b want 1", i, gnt0);
            end
            next();
        end
        drain_req = 1'b1;
        req1 = 1'b1;
        look();
        d = cyc;
        z = -1;
        r = -1;
        bad = 0;
        t = 0;
        while (r < 0 && t < 40) begin
            if (gnt0 | gnt1) bad++;
            if (inflight == CW'(0) && z < 0) z = cyc;
            if (drained && r < 0) r = cyc;
            if (r < 0) begin
                next();
                look();
            end
            t++;
        end
        n_chk++;
        if (bad !== 0 || dq.size() !== 3) begin
            n_err++;
            $display("FAIL drain_quiet got grants%0d dones%0d want 0/3", bad, dq.size());
        end
        n_chk++;
        if (z !== d + LAT + 1 || r !== z + 1) begin
            n_err++;
            $display("FAIL drain_timing got zero@%0d drained@%0d want %0d/%0d",
                     z, r, d + LAT + 1, d + LAT + 2);
        end
        next();
        drain_req = 1'b0;
        look();
        n_chk++;
        if ({drained, gnt0, gnt1} !== 3'b100) begin
            n_err++;
            $display("FAIL drain_hold got %b want 100", {drained, gnt0, gnt1});
        end
        next();
        look();
        n_chk++;
        if ({drained, gnt0, gnt1} !== 3'b001) begin
            n_err++;
            $display("FAIL drain_resume got %b want 001", {drained, gnt0, gnt1});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        next();
    endtask

    task automatic test_reset_midflight();
        int gc;
        do_reset();
        opx0 = 32'h3F800000;
        opy0 = 32'h40000000;
        opx1 = 32'hC0000000;
        opy1 = 32'h40800000;
        req0 = 1'b1;
        req1 = 1'b1;
        next();
        next();
        req0 = 1'b0;
        req1 = 1'b0;
        look();
        n_chk++;
        if (inflight !== CW'(2) || mul_vld !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre got %0d/%b want 2/1", inflight, mul_vld);
        end
        RST = 1'b0;
        #1;
        n_chk++;
        if ({mul_vld, done0, done1, gnt0, gnt1, drained} !== 6'b0 ||
            mul_x !== 32'h0 || mul_y !== 32'h0 || res_data !== 32'h0 ||
            inflight !== CW'(0)) begin
            n_err++;
            $display("FAIL mid_async got %b %h %h %h %0d want 0 0 0 0 0",
                     {mul_vld, done0, done1, gnt0, gnt1, drained},
                     mul_x, mul_y, res_data, inflight);
        end
        dq.delete();
        next();
        RST = 1'b1;
        repeat (LAT + 4) next();
        n_chk++;
        if (dq.size() !== 0) begin
            n_err++;
            $display("FAIL mid_ghost got %0d dones want 0", dq.size());
        end
        opx1 = 32'h40000000;
        opy1 = 32'h40000000;
        req1 = 1'b1;
        look();
        gc = cyc;
        n_chk++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_regrant got %b want 01", {gnt0, gnt1});
        end
        next();
        req1 = 1'b0;
        repeat (LAT + 3) next();
        n_chk++;
        if (dq.size() !== 1) begin
            n_err++;
            $display("FAIL mid_done got %0d dones want 1", dq.size());
        end else if (dq[0].c !== gc + LAT + 2 || dq[0].id !== 1 ||
                     dq[0].d !== 32'h40800000) begin
            n_err++;
            $display("FAIL mid_done got c%0d id%0d %h want c%0d id1 40800000",
                     dq[0].c, dq[0].id, dq[0].d, gc + LAT + 2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_drain();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
